// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: instruction-decode inputs, mem handshake and datapath control strobes
interface cpu_control_fsm_if;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_ready;
  logic [3:0] vsel;
  logic [2:0] nsel;
  logic       write;
  logic       loada;
  logic       loadb;
  logic       asel;
  logic       bsel;
  logic       loadc;
  logic       loads;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic       halted;
  logic       fault;
  modport master (
    input  opcode, op, mem_ready,
    output vsel, nsel, write, loada, loadb, asel, bsel, loadc, loads,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted, fault
  );
  modport slave (
    output opcode, op, mem_ready,
    input  vsel, nsel, write, loada, loadb, asel, bsel, loadc, loads,
           load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted, fault
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: Moore control sequencer for fetch/decode/execute with memory handshake and wait timeout
module cpu_control_fsm #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input logic clk,
  input logic reset,
  cpu_control_fsm_if.master ctrl
);
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_MOVIMM, S_MOVR1, S_MOVR2,
    S_GETA, S_GETB, S_ALU, S_CMP, S_WRREG, S_LDA, S_ADR, S_LADR,
    S_MRD, S_WRMD, S_STB, S_STC, S_MWR, S_HALT
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d;
  logic wait_st, timeout;
  always_comb begin
    wait_st = state_q inside {S_IF1, S_MRD, S_MWR};
    timeout = (MAX_WAIT != 0) && wait_st && !ctrl.mem_ready && (cnt_q == CNT_W'(MAX_WAIT));
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF1;
      S_IF1:    state_d = ctrl.mem_ready ? S_IF2 : timeout ? S_HALT : S_IF1;
      S_IF2:    state_d = S_UPC;
      S_UPC:    state_d = S_DEC;
      S_DEC:
        casez ({ctrl.opcode, ctrl.op})
          5'b110_10:          state_d = S_MOVIMM;
          5'b110_00:          state_d = S_MOVR1;
          5'b101_??:          state_d = S_GETA;
          5'b011_00, 5'b100_00: state_d = S_LDA;
          5'b111_??:          state_d = S_HALT;
          default:            state_d = S_IF1;
        endcase
      S_MOVIMM: state_d = S_IF1;
      S_MOVR1:  state_d = S_MOVR2;
      S_MOVR2:  state_d = S_WRREG;
      S_GETA:   state_d = S_GETB;
      S_GETB:   state_d = (ctrl.op == 2'b01) ? S_CMP : S_ALU;
      S_ALU:    state_d = S_WRREG;
      S_CMP:    state_d = S_IF1;
      S_WRREG:  state_d = S_IF1;
      S_LDA:    state_d = S_ADR;
      S_ADR:    state_d = S_LADR;
      S_LADR:   state_d = (ctrl.opcode == 3'b011) ? S_MRD : S_STB;
      S_MRD:    state_d = ctrl.mem_ready ? S_WRMD : timeout ? S_HALT : S_MRD;
      S_WRMD:   state_d = S_IF1;
      S_STB:    state_d = S_STC;
      S_STC:    state_d = S_MWR;
      S_MWR:    state_d = ctrl.mem_ready ? S_IF1 : timeout ? S_HALT : S_MWR;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_RST;
    endcase
  end
  // any state change restarts the wait count, so each entry to a wait state begins at zero
  always_comb begin
    cnt_d   = (state_d != state_q) ? '0 : (wait_st && !ctrl.mem_ready) ? cnt_q + 1'b1 : cnt_q;
    fault_d = fault_q | timeout;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  always_comb begin
    ctrl.vsel      = 4'b0000;
    ctrl.nsel      = 3'b000;
    ctrl.write     = 1'b0;
    ctrl.loada     = 1'b0;
    ctrl.loadb     = 1'b0;
    ctrl.asel      = 1'b0;
    ctrl.bsel      = 1'b0;
    ctrl.loadc     = 1'b0;
    ctrl.loads     = 1'b0;
    ctrl.load_ir   = 1'b0;
    ctrl.load_pc   = 1'b0;
    ctrl.reset_pc  = 1'b0;
    ctrl.addr_sel  = 1'b0;
    ctrl.load_addr = 1'b0;
    ctrl.mem_cmd   = 2'b00;
    ctrl.halted    = 1'b0;
    ctrl.fault     = fault_q;
    case (state_q)
      S_RST: begin
        ctrl.reset_pc = 1'b1;
        ctrl.load_pc  = 1'b1;
      end
      S_IF1: begin
        ctrl.addr_sel = 1'b1;
        ctrl.mem_cmd  = 2'b01;
      end
      S_IF2: begin
        ctrl.addr_sel = 1'b1;
        ctrl.mem_cmd  = 2'b01;
        ctrl.load_ir  = 1'b1;
      end
      S_UPC: ctrl.load_pc = 1'b1;
      S_MOVIMM: begin
        ctrl.nsel  = 3'b010;
        ctrl.vsel  = 4'b0100;
        ctrl.write = 1'b1;
      end
      S_MOVR1, S_GETB: begin
        ctrl.nsel  = 3'b001;
        ctrl.loadb = 1'b1;
      end
      S_MOVR2, S_STC: begin
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_GETA, S_LDA: begin
        ctrl.nsel  = 3'b100;
        ctrl.loada = 1'b1;
      end
      S_ALU: ctrl.loadc = 1'b1;
      S_CMP: ctrl.loads = 1'b1;
      S_WRREG: begin
        ctrl.nsel  = 3'b010;
        ctrl.vsel  = 4'b0001;
        ctrl.write = 1'b1;
      end
      S_ADR: begin
        ctrl.bsel  = 1'b1;
        ctrl.loadc = 1'b1;
      end
      S_LADR: ctrl.load_addr = 1'b1;
      S_MRD: ctrl.mem_cmd = 2'b01;
      S_WRMD: begin
        ctrl.mem_cmd = 2'b01;
        ctrl.nsel    = 3'b010;
        ctrl.vsel    = 4'b1000;
        ctrl.write   = 1'b1;
      end
      S_STB: begin
        ctrl.nsel  = 3'b010;
        ctrl.loadb = 1'b1;
      end
      S_MWR: ctrl.mem_cmd = 2'b11;
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed per-cycle vectors; expected Moore outputs queued by stimulus, checked by a monitor
module tb_cpu_control_fsm;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  cpu_control_fsm_if bus();
  cpu_control_fsm #(.MAX_WAIT(4), .CNT_W(3)) dut (.clk(clk), .reset(reset), .ctrl(bus));
  always #5 clk = ~clk;
  // {vsel, nsel, write,loada,loadb,asel,bsel,loadc,loads,load_ir,load_pc,reset_pc,addr_sel,load_addr, mem_cmd, halted, fault}
  function automatic logic [22:0] ev(logic [3:0] vs, logic [2:0] ns, logic [11:0] f, logic [1:0] mc, logic h);
    return {vs, ns, f, mc, h, 1'b0};
  endfunction
  localparam logic [22:0] E_RST  = ev(4'b0000, 3'b000, 12'b0000_0000_1100, 2'b00, 1'b0);
  localparam logic [22:0] E_IF1  = ev(4'b0000, 3'b000, 12'b0000_0000_0010, 2'b01, 1'b0);
  localparam logic [22:0] E_IF2  = ev(4'b0000, 3'b000, 12'b0000_0001_0010, 2'b01, 1'b0);
  localparam logic [22:0] E_UPC  = ev(4'b0000, 3'b000, 12'b0000_0000_1000, 2'b00, 1'b0);
  localparam logic [22:0] E_DEC  = ev(4'b0000, 3'b000, 12'b0000_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_MOVI = ev(4'b0100, 3'b010, 12'b1000_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_RDB  = ev(4'b0000, 3'b001, 12'b0010_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_SHA  = ev(4'b0000, 3'b000, 12'b0001_0100_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_RDA  = ev(4'b0000, 3'b100, 12'b0100_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_ALU  = ev(4'b0000, 3'b000, 12'b0000_0100_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_CMP  = ev(4'b0000, 3'b000, 12'b0000_0010_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_WRR  = ev(4'b0001, 3'b010, 12'b1000_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_ADR  = ev(4'b0000, 3'b000, 12'b0000_1100_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_LADR = ev(4'b0000, 3'b000, 12'b0000_0000_0001, 2'b00, 1'b0);
  localparam logic [22:0] E_MRD  = ev(4'b0000, 3'b000, 12'b0000_0000_0000, 2'b01, 1'b0);
  localparam logic [22:0] E_WRMD = ev(4'b1000, 3'b010, 12'b1000_0000_0000, 2'b01, 1'b0);
  localparam logic [22:0] E_STB  = ev(4'b0000, 3'b010, 12'b0010_0000_0000, 2'b00, 1'b0);
  localparam logic [22:0] E_MWR  = ev(4'b0000, 3'b000, 12'b0000_0000_0000, 2'b11, 1'b0);
  localparam logic [22:0] E_HLT  = ev(4'b0000, 3'b000, 12'b0000_0000_0000, 2'b00, 1'b1);
  localparam logic [22:0] E_HLTF = E_HLT | 23'd1;
  typedef struct {
    logic [22:0] e;
    string       n;
  } exp_t;
  exp_t q[$];
  logic [22:0] act;
  assign act = {bus.vsel, bus.nsel, bus.write, bus.loada, bus.loadb, bus.asel, bus.bsel, bus.loadc,
                bus.loads, bus.load_ir, bus.load_pc, bus.reset_pc, bus.addr_sel, bus.load_addr,
                bus.mem_cmd, bus.halted, bus.fault};
  task automatic cyc(input logic r, input logic [2:0] opc, input logic [1:0] o, input logic rdy,
                     input logic [22:0] e, input string nm);
    reset         = r;
    bus.opcode    = opc;
    bus.op        = o;
    bus.mem_ready = rdy;
    q.push_back('{e: e, n: nm});
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [2:0] opc, input logic [1:0] o);
    cyc(1'b1, opc, o, 1'b1, E_IF1, "if1");
    cyc(1'b1, opc, o, 1'b0, E_IF2, "if2");
    cyc(1'b1, opc, o, 1'b1, E_UPC, "upc");
    cyc(1'b1, opc, o, 1'b0, E_DEC, "dec");
  endtask
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        checks++;
        if (act !== x.e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h t=%0t", x.n, act, x.e, $time);
        end
      end
    end
  end
  initial begin
    reset = 1'b0;
    bus.opcode = 3'b000;
    bus.op = 2'b00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 3'b000, 2'b00, 1'b0, E_RST, "rst");
    fetch(3'b110, 2'b10);
    cyc(1'b1, 3'b110, 2'b10, 1'b0, E_MOVI, "movimm");
    fetch(3'b101, 2'b01);
    cyc(1'b1, 3'b101, 2'b01, 1'b1, E_RDA, "cmp_geta");
    cyc(1'b1, 3'b101, 2'b01, 1'b1, E_RDB, "cmp_getb");
    cyc(1'b1, 3'b101, 2'b01, 1'b1, E_CMP, "cmp");
    fetch(3'b110, 2'b00);
    cyc(1'b1, 3'b110, 2'b00, 1'b0, E_RDB, "movr1");
    cyc(1'b1, 3'b110, 2'b00, 1'b0, E_SHA, "movr2");
    cyc(1'b1, 3'b110, 2'b00, 1'b0, E_WRR, "movr_wr");
    fetch(3'b101, 2'b00);
    cyc(1'b1, 3'b101, 2'b00, 1'b0, E_RDA, "alu_geta");
    cyc(1'b1, 3'b101, 2'b00, 1'b0, E_RDB, "alu_getb");
    cyc(1'b1, 3'b101, 2'b00, 1'b0, E_ALU, "alu");
    cyc(1'b0, 3'b101, 2'b00, 1'b0, E_RST, "rst_abort");
    cyc(1'b1, 3'b101, 2'b00, 1'b0, E_RST, "rst_release");
    fetch(3'b011, 2'b00);
    cyc(1'b1, 3'b011, 2'b00, 1'b1, E_RDA, "ldr_lda");
    cyc(1'b1, 3'b011, 2'b00, 1'b1, E_ADR, "ldr_adr");
    cyc(1'b1, 3'b011, 2'b00, 1'b1, E_LADR, "ldr_ladr");
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'b011, 2'b00, 1'b0, E_MRD, "ldr_mrd_wait");
    cyc(1'b1, 3'b011, 2'b00, 1'b1, E_MRD, "ldr_mrd_rdy");
    cyc(1'b1, 3'b011, 2'b00, 1'b0, E_WRMD, "ldr_wrmd");
    fetch(3'b100, 2'b00);
    cyc(1'b1, 3'b100, 2'b00, 1'b0, E_RDA, "str_lda");
    cyc(1'b1, 3'b100, 2'b00, 1'b0, E_ADR, "str_adr");
    cyc(1'b1, 3'b100, 2'b00, 1'b0, E_LADR, "str_ladr");
    cyc(1'b1, 3'b100, 2'b00, 1'b1, E_STB, "str_stb");
    cyc(1'b1, 3'b100, 2'b00, 1'b1, E_SHA, "str_stc");
    cyc(1'b1, 3'b100, 2'b00, 1'b0, E_MWR, "str_mwr_wait");
    cyc(1'b1, 3'b100, 2'b00, 1'b0, E_MWR, "str_mwr_wait");
    cyc(1'b1, 3'b100, 2'b00, 1'b1, E_MWR, "str_mwr_rdy");
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'b000, 2'b00, 1'b0, E_IF1, "edge_wait");
    fetch(3'b000, 2'b00);
    fetch(3'b111, 2'b00);
    for (int i = 0; i < 20; i++) begin
      logic [4:0] v;
      v = 5'(i);
      cyc(1'b1, v[2:0], v[1:0], v[0], E_HLT, "halt_hold");
    end
    cyc(1'b0, 3'b000, 2'b00, 1'b0, E_RST, "rst_halt");
    cyc(1'b1, 3'b000, 2'b00, 1'b0, E_RST, "rst_release2");
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'b000, 2'b00, 1'b0, E_IF1, "to_wait");
    for (int i = 0; i < 6; i++) begin
      logic [4:0] v;
      v = 5'(i + 3);
      cyc(1'b1, v[2:0], v[1:0], v[0], E_HLTF, "halt_fault");
    end
    cyc(1'b0, 3'b000, 2'b00, 1'b0, E_RST, "rst_fault_clr");
    cyc(1'b1, 3'b000, 2'b00, 1'b0, E_RST, "rst_release3");
    cyc(1'b1, 3'b000, 2'b00, 1'b0, E_IF1, "if1_after");
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
